seq_stream_ctrl: RTL
====================

// Module: seq_stream_ctrl
// PURPOSE
//  Sequencing controller for the serial pattern-detect datapath. Accepts parallel words over a
//  valid/ready handshake and serialises each word MSB-first, one bit per clock. Runs an
//  overlapping match against PATTERN, keeping bit history across word boundaries. Reports
//  per-word and running match counts. Sits between a word-oriented producer and status/CSR logic.
// PARAMETERS
//  WORD_W   8        data word width (>= 2)
//  PAT_W    4        pattern length in bits (2..WORD_W)
//  PATTERN  4'b1011  pattern matched, MSB = oldest bit
//  CNT_W    16       width of running match counter
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  asynchronous active-low reset
//  enable         in   1                  0: refuse new words; pause shifting
//  clear          in   1                  sync clear: counters, history, flags; aborts any word
//  s_valid        in   1                  input word valid
//  s_ready        out  1                  input word accepted when s_valid && s_ready
//  s_data         in   WORD_W             input word, MSB shifted first
//  bit_out        out  1                  bit currently being serialised
//  bit_valid      out  1                  bit_out valid; high only in SHIFT
//  match_pulse    out  1                  1-cycle pulse, cycle after the bit completing PATTERN
//  word_done      out  1                  1-cycle pulse in REPORT state
//  word_hits      out  $clog2(WORD_W+1)   matches ending inside the last word; valid with word_done
//  match_count    out  CNT_W              running match total, saturating
//  overflow       out  1                  sticky; set when a match arrives with match_count all-ones
//  busy           out  1                  state != IDLE
// BEHAVIOUR
//  Reset: all outputs are 0; state IDLE; history and fill count are 0.
//  FSM states:
//   IDLE:   s_ready = enable && !clear.
//           On handshake, capture s_data, set bit_idx = WORD_W-1, zero word_hits, go to SHIFT.
//   SHIFT:  bit_out = word[bit_idx]; bit_valid = enable.
//           With enable=1, each cycle consumes one bit.
//           After bit_idx reaches 0, go to REPORT.
//           With enable=0, hold all state; bit_valid = 0; no history update.
//   REPORT: word_done = 1 for exactly one cycle; word_hits holds the final value.
//           Go to IDLE. s_ready = 0 in this state.
//  Timing: handshake in cycle N; bits in cycles N+1..N+WORD_W; word_done in N+WORD_W+1.
//   With enable held high, next word accepted no earlier than N+WORD_W+2.
//  Detection, on each consumed bit b:
//   - win = {hist[PAT_W-2:0], b}
//   - hit = (fill >= PAT_W-1) && (win == PATTERN)
//   - update: hist <= win[PAT_W-2:0]; fill saturates at PAT_W-1
//   Registered effects of hit:
//   - match_pulse <= hit
//   - word_hits += hit
//   - match_count += hit, saturating at 2^CNT_W-1
//  Matches are overlapping, e.g. 1011011 gives 2 matches for PATTERN 1011.
//  History persists across words and IDLE gaps; only reset and clear empty it.
//  A hit on a word's last bit has match_pulse in the REPORT cycle and is counted in word_hits.
//  overflow sets when hit=1 and match_count is already all-ones. It stays set until clear or reset.
//  clear has priority over everything and takes effect next cycle:
//   - next state IDLE
//   - hist, fill, word_hits, match_count and overflow are zeroed
//   - no word_done for an aborted word
//   - s_ready = 0 in the clear cycle
//  An s_valid/clear collision is not accepted.
//  s_data is sampled only at the handshake. Changes to s_data while busy are ignored.
// TESTING
//  T1: s_data=8'hB0 (1011_0000), enable=1.
//      -> match_pulse one cycle after 4th bit; word_done at N+9; word_hits=1; match_count=1.
//  T2: s_data=8'hB6 (1011_0110), overlapping.
//      -> word_hits=2; pulses after bits 4 and 7; match_count=2.
//  T3: cross-word, 8'h05 then 8'h80, after clear.
//      -> word1 word_hits=0; word2 word_hits=1, pulse after word2 bit 1; match_count=1.
//  T4: enable=0 for 3 cycles mid-word (after bit 3) of 8'hB0.
//      -> bit_valid low and state held during the pause; word_done delayed 3 cycles; word_hits=1.
//  T5: clear asserted during bit 5 of 8'hB0.
//      -> no word_done; match_count=0; busy=0 next cycle; next word 8'h0B gives word_hits=1.
//  T6: CNT_W=2; 5 back-to-back 8'hB0 words.
//      -> match_count saturates at 3; overflow=1 after the 4th hit, sticky until clear.

Source files
------------

// File: rtl/seq_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq_stream_ctrl
//   Accepts parallel words over a valid/ready handshake and serialises each one
//   MSB-first, one bit per clock. Each consumed bit is matched against PATTERN
//   using an overlapping window whose history survives word boundaries and idle
//   gaps. Per-word and running (saturating) match counts are reported.
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready. s_ready
//   is high only in IDLE with enable=1 and clear=0. s_data is sampled only on
//   that edge, and s_valid may be dropped or held freely afterwards.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   enable          0: refuse new words and pause shifting
//   clear           synchronous clear of counters/history/flags, aborts a word
//   s_valid/s_ready/s_data   word input handshake
//   bit_out/bit_valid        serialised bit, valid only while shifting
//   match_pulse     one-cycle pulse the cycle after a bit completes PATTERN
//   word_done       one-cycle pulse in REPORT; word_hits valid with it
//   word_hits       matches ending inside the last word
//   match_count     running match total, saturating at all-ones
//   overflow        sticky: a match arrived while match_count was all-ones
//   busy            controller is not idle
//   dbg_state_o     current FSM state (0 idle, 1 shift, 2 report)
// -----------------------------------------------------------------------------
module seq_stream_ctrl #(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_W-1:0]             s_data,
    output logic                          bit_out,
    output logic                          bit_valid,
    output logic                          match_pulse,
    output logic                          word_done,
    output logic [$clog2(WORD_W+1)-1:0]   word_hits,
    output logic [CNT_W-1:0]              match_count,
    output logic                          overflow,
    output logic                          busy,
    output logic [1:0]                    dbg_state_o
);

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W);
    localparam int HIT_W  = $clog2(WORD_W + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [WORD_W-1:0] word_q,    word_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [PAT_W-2:0]  hist_q,    hist_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic [HIT_W-1:0]  hits_q,    hits_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              ovf_q,     ovf_d;
    logic              pulse_q,   pulse_d;

    logic             cur_bit;
    logic [PAT_W-1:0] win;
    logic             consume;
    logic             hit;

    assign cur_bit = word_q[bit_idx_q];
    assign win     = {hist_q, cur_bit};
    // A clear cycle consumes nothing: its effects are wiped on the same edge.
    assign consume = (state_q == ST_SHIFT) && enable && !clear;
    // fill saturates at PAT_W-1, so equality means "history fully primed".
    assign hit     = consume && (fill_q == FILL_FULL) && (win == PATTERN);

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_idx_d = bit_idx_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        hits_d    = hits_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        pulse_d   = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            hist_d  = '0;
            fill_d  = '0;
            hits_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid && enable) begin
                        word_d    = s_data;
                        bit_idx_d = IDX_LAST;
                        hits_d    = '0;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (consume) begin
                        hist_d = win[PAT_W-2:0];
                        if (fill_q != FILL_FULL) begin
                            fill_d = fill_q + 1'b1;
                        end
                        if (hit) begin
                            pulse_d = 1'b1;
                            hits_d  = hits_q + 1'b1;
                            if (&count_q) begin
                                ovf_d = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                        if (bit_idx_q == '0) begin
                            state_d = ST_REPORT;
                        end else begin
                            bit_idx_d = bit_idx_q - 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            bit_idx_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            hits_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_idx_q <= bit_idx_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            hits_q    <= hits_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            pulse_q   <= pulse_d;
        end
    end

    assign s_ready     = (state_q == ST_IDLE) && enable && !clear;
    assign bit_out     = (state_q == ST_SHIFT) ? cur_bit : 1'b0;
    assign bit_valid   = (state_q == ST_SHIFT) && enable;
    assign match_pulse = pulse_q;
    assign word_done   = (state_q == ST_REPORT);
    assign word_hits   = hits_q;
    assign match_count = count_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule
